shared_mem_arbiter: RTL and testbench
=====================================

Name: shared_mem_arbiter

Overview:
- Shares one single-port data RAM among N_PORTS requesters, e.g. several simple CPU cores in a multi-core build or a CPU plus a host/debug port.
- Each requester issues one word read or write with a level req / pulse ack handshake.
- A round-robin scheduler grants one access at a time and sequences the RAM's 1-cycle registered read latency.
- Sits between the cores' load/store paths and a single shared single_port_ram instance inside this block.

Parameters:
- N_PORTS, 4, number of requesters (2..8).
- WIDTH_D, 32, data word width.
- DEPTH_D, 8, address width; RAM holds 2^DEPTH_D words.
- W_ID, 2, width of grant index; must satisfy 2^W_ID >= N_PORTS.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  N_PORTS  per-port request level; held until ack.
- we  in  N_PORTS  per-port write enable (1=write, 0=read); stable while req high.
- addr  in  N_PORTS*DEPTH_D  per-port word address; port i uses bits [i*DEPTH_D +: DEPTH_D].
- wdata  in  N_PORTS*WIDTH_D  per-port write data; port i uses bits [i*WIDTH_D +: WIDTH_D].
- ack  out  N_PORTS  one-cycle completion pulse, one-hot or zero.
- rdata  out  WIDTH_D  shared read data; valid in the cycle ack is high for a read.
- busy  out  1  high whenever state is not S_IDLE.
- grant_id  out  W_ID  index of current or last granted port.

Behaviour:
- Reset values: ack=0, rdata=0, busy=0, grant_id=N_PORTS-1, state=S_IDLE, RAM we=0.
- Round-robin pointer last=N_PORTS-1 at reset, so port 0 wins the first contention.
- RAM contents are not cleared by reset.
- FSM states: S_IDLE, S_MEM, S_DATA, S_DONE.
- S_IDLE:
  - If any req bit is set, pick the first set bit searching from last+1 upward, wrapping modulo N_PORTS.
  - Register grant_id and last to that port.
  - Drive RAM addr/data_in/we from that port's addr/wdata/we; go to S_MEM.
  - If no req is set, stay in S_IDLE with RAM we=0.
- S_MEM: RAM samples address/write at this edge. Set RAM we=0; go to S_DATA.
- S_DATA:
  - For a read, rdata <= RAM data_out; for a write, rdata is unchanged.
  - ack[grant_id] <= 1; go to S_DONE.
- S_DONE: ack <= 0; go to S_IDLE. Requests are ignored in this state, so a requester dropping req after seeing ack is never re-granted.
- Timing:
  - Req sampled at edge E, so ack is high in the cycle after edge E+2: 3-cycle latency.
  - One access per 4 cycles maximum; a port requesting back-to-back re-raises req at the earliest in the cycle after ack.
- Requester rules:
  - req, we, addr and wdata must stay stable from assertion until ack is seen.
  - Deassert req at the edge where ack is sampled high, or re-issue with new operands.
- Arbitration:
  - Fairness: with all ports continuously requesting, grants rotate 0,1,..,N-1,0,...
  - No port waits more than N_PORTS-1 other grants.
  - A req deasserted before grant is simply not served; the block has no memory of it.
- RAM write pulse: RAM we is high exactly one cycle (S_MEM) per write access and never for reads.
- Reset mid-operation: any state returns to S_IDLE next cycle, ack=0, RAM we=0. An access in S_MEM may or may not have been written; the bench treats it as undefined.
- Simultaneous events: requests arriving while busy wait; arbitration uses only req values sampled in S_IDLE.

Decomposition:
- Shared package: FSM state encodings (S_IDLE=0, S_MEM=1, S_DATA=2, S_DONE=3), TRUE/FALSE, and a round-robin next-grant function taking (req, last).
- One sub-module: the existing single_port_ram (DATA_WIDTH=WIDTH_D, ADDR_WIDTH=DEPTH_D), instantiated once.
- The arbiter priority search stays inline in this module.

Test Plan:
- Single port: port 0 writes 0xDEADBEEF at addr 0x10 and gets ack 3 cycles after req. It then reads 0x10 and gets rdata=0xDEADBEEF with ack; RAM we high exactly 1 cycle total.
- All 4 ports request reads of addrs 1,2,3,4 in the same cycle after reset (RAM preloaded with 0x11,0x22,0x33,0x44). Acks arrive in order 0,1,2,3, 4 cycles apart, with rdata 0x11,0x22,0x33,0x44.
- Port 0 and port 2 request continuously for 8 accesses: grants alternate 0,2,0,2,...; neither port is granted twice in a row while the other waits.
- Port 1 writes 0x5 to addr 7 while port 3 waits to read addr 7. The read is granted after the write and returns 0x5.
- Reset asserted in S_DATA: next cycle ack=0, busy=0, grant_id=3. A new req from port 2 then completes normally with 3-cycle latency.
- Port 0 drops req before being granted while port 1 still requests: only port 1 is acked, and ack[0] never pulses.

Source files
------------

// File: rtl/shared_mem_arbiter_pkg.sv
// Shared definitions for the shared-memory arbiter: FSM encoding, boolean
// constants and the round-robin grant search.
package shared_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int MAX_PORTS = 8;
    localparam int PICK_W    = 3;

    // First set request bit strictly after 'last', wrapping modulo n_ports.
    // Returns 'last' unchanged when no request is set.
    function automatic logic [PICK_W-1:0] rr_next_grant(
        input logic [MAX_PORTS-1:0] req,
        input logic [PICK_W-1:0]    last,
        input int                   n_ports
    );
        logic [PICK_W-1:0] pick;
        logic              found;
        int                idx;
        pick  = last;
        found = FALSE;
        for (int i = 1; i <= MAX_PORTS; i++) begin
            idx = (int'(last) + i) % n_ports;
            if ((i <= n_ports) && !found && req[idx[PICK_W-1:0]]) begin
                pick  = PICK_W'(idx);
                found = TRUE;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/shared_mem_arbiter_ram.sv
// Single-port RAM with synchronous write and a registered (read-first) read port.
// Contents are deliberately not reset.
module single_port_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= data_in;
        end
        data_out <= mem[addr];
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among N_PORTS requesters.
// Each access takes IDLE -> MEM -> DATA -> DONE, so at most one access per 4 cycles.
module shared_mem_arbiter
    import shared_mem_arbiter_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int WIDTH_D = 32,
    parameter int DEPTH_D = 8,
    parameter int W_ID    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_PORTS-1:0]         req,
    input  logic [N_PORTS-1:0]         we,
    input  logic [N_PORTS*DEPTH_D-1:0] addr,
    input  logic [N_PORTS*WIDTH_D-1:0] wdata,
    output logic [N_PORTS-1:0]         ack,
    output logic [WIDTH_D-1:0]         rdata,
    output logic                       busy,
    output logic [W_ID-1:0]            grant_id
);

    state_t               state;
    state_t               state_next;
    logic [W_ID-1:0]      grant_q;
    logic [W_ID-1:0]      pick;
    logic [DEPTH_D-1:0]   sel_addr;
    logic [WIDTH_D-1:0]   sel_wdata;
    logic                 sel_we;
    logic [N_PORTS-1:0]   ack_onehot;
    logic                 op_write;

    logic                 ram_we;
    logic [DEPTH_D-1:0]   ram_addr;
    logic [WIDTH_D-1:0]   ram_din;
    logic [WIDTH_D-1:0]   ram_dout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // grant_q doubles as the round-robin 'last' pointer and the grant_id output.
    always_comb begin
        state_next = state;
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_we     = FALSE;
        ack_onehot = '0;
        pick       = W_ID'(rr_next_grant(MAX_PORTS'(req), PICK_W'(grant_q), N_PORTS));
        for (int i = 0; i < N_PORTS; i++) begin
            if (pick == W_ID'(i)) begin
                sel_addr  = addr[i*DEPTH_D +: DEPTH_D];
                sel_wdata = wdata[i*WIDTH_D +: WIDTH_D];
                sel_we    = we[i];
            end
            ack_onehot[i] = (grant_q == W_ID'(i));
        end
        case (state)
            S_IDLE:  if (|req) state_next = S_MEM;
            S_MEM:   state_next = S_DATA;
            S_DATA:  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack      <= '0;
            rdata    <= '0;
            grant_q  <= W_ID'(N_PORTS - 1);
            ram_we   <= FALSE;
            ram_addr <= '0;
            ram_din  <= '0;
            op_write <= FALSE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        grant_q  <= pick;
                        ram_addr <= sel_addr;
                        ram_din  <= sel_wdata;
                        ram_we   <= sel_we;
                        op_write <= sel_we;
                    end else begin
                        ram_we <= FALSE;
                    end
                end
                S_MEM: begin
                    ram_we <= FALSE;
                end
                S_DATA: begin
                    if (!op_write) begin
                        rdata <= ram_dout;
                    end
                    ack <= ack_onehot;
                end
                S_DONE: begin
                    ack <= '0;
                end
                default: begin
                    ack    <= '0;
                    ram_we <= FALSE;
                end
            endcase
        end
    end

    assign busy     = (state != S_IDLE);
    assign grant_id = grant_q;

    single_port_ram #(
        .DATA_WIDTH(WIDTH_D),
        .ADDR_WIDTH(DEPTH_D)
    ) u_ram (
        .clk      (clk),
        .we       (ram_we),
        .addr     (ram_addr),
        .data_in  (ram_din),
        .data_out (ram_dout)
    );

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Scoreboard bench for shared_mem_arbiter: stimulus pushes expected acks,
// an independent negedge monitor pops and compares them.
module tb_shared_mem_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic [IW-1:0]   grant_id;

    typedef struct {
        int          port;
        logic        is_read;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   we_count = 0;
    int   ack0_pulses = 0;
    int   ack_cycle[N];
    logic [31:0] pre_vals[4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    shared_mem_arbiter #(
        .N_PORTS(N), .WIDTH_D(DW), .DEPTH_D(AW), .W_ID(IW)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int port, input logic w, input logic [7:0] a, input logic [31:0] d);
        we[port]             = w;
        addr[port*AW +: AW]  = a;
        wdata[port*DW +: DW] = d;
        req[port]            = 1'b1;
    endtask

    task automatic expectAck(input int port, input logic is_read, input logic [31:0] data);
        exp_t e;
        e.port    = port;
        e.is_read = is_read;
        e.data    = data;
        sb.push_back(e);
    endtask

    // Waits for n acks within budget cycles, recording the cycle each port was acked.
    task automatic waitAcks(input int n, input int budget, input logic drop);
        int cyc = 0;
        int got = 0;
        while (got < n && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            for (int p = 0; p < N; p++) begin
                if (ack[p]) begin
                    got++;
                    ack_cycle[p] = cyc;
                    if (drop) req[p] = 1'b0;
                end
            end
        end
        checkOutput("ack_count_within_budget", 32'(got), 32'(n));
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (dut.ram_we) we_count++;
            if (ack[0]) ack0_pulses++;
            if (ack != '0) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("ack_port", 32'(ack), 32'(1) << mon_e.port);
                    if (mon_e.is_read) checkOutput("rdata", rdata, mon_e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset_ack", 32'(ack), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_grant_id", 32'(grant_id), 32'd3);
        checkOutput("reset_rdata", rdata, 32'd0);

        $display("[TB] single port write then read");
        we_count = 0;
        expectAck(0, 1'b0, 32'h0);
        applyStimulus(0, 1'b1, 8'h10, 32'hDEADBEEF);
        waitAcks(1, 20, 1'b1);
        checkOutput("write_latency", 32'(ack_cycle[0]), 32'd3);
        expectAck(0, 1'b1, 32'hDEADBEEF);
        applyStimulus(0, 1'b0, 8'h10, 32'h0);
        waitAcks(1, 20, 1'b1);
        checkOutput("read_latency", 32'(ack_cycle[0]), 32'd3);
        checkOutput("ram_we_cycles", 32'(we_count), 32'd1);

        $display("[TB] preload then four simultaneous reads");
        for (int k = 0; k < 4; k++) begin
            expectAck(0, 1'b0, 32'h0);
            applyStimulus(0, 1'b1, 8'(k + 1), pre_vals[k]);
            waitAcks(1, 20, 1'b1);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int p = 0; p < N; p++) begin
            expectAck(p, 1'b1, pre_vals[p]);
            applyStimulus(p, 1'b0, 8'(p + 1), 32'h0);
        end
        waitAcks(4, 60, 1'b1);
        for (int p = 0; p < N; p++) begin
            checkOutput("contention_ack_cycle", 32'(ack_cycle[p]), 32'(3 + 4 * p));
        end

        $display("[TB] ports 0 and 2 continuously requesting");
        for (int k = 0; k < 4; k++) begin
            expectAck(0, 1'b1, 32'h11);
            expectAck(2, 1'b1, 32'h33);
        end
        applyStimulus(0, 1'b0, 8'd1, 32'h0);
        applyStimulus(2, 1'b0, 8'd3, 32'h0);
        waitAcks(8, 60, 1'b0);
        req = '0;
        checkOutput("alternate_last_port2", 32'(ack_cycle[2]), 32'd31);
        checkOutput("alternate_last_port0", 32'(ack_cycle[0]), 32'd27);

        $display("[TB] write by port 1 before waiting read by port 3");
        expectAck(1, 1'b0, 32'h0);
        expectAck(3, 1'b1, 32'h5);
        applyStimulus(1, 1'b1, 8'd7, 32'h5);
        @(posedge clk); #1;
        applyStimulus(3, 1'b0, 8'd7, 32'h0);
        waitAcks(2, 30, 1'b1);
        checkOutput("write_then_read_gap", 32'(ack_cycle[3] - ack_cycle[1]), 32'd4);

        $display("[TB] reset asserted in S_DATA");
        applyStimulus(0, 1'b0, 8'h10, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("midreset_ack", 32'(ack), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_grant_id", 32'(grant_id), 32'd3);
        reset  = 1'b0;
        req[0] = 1'b0;
        expectAck(2, 1'b1, 32'h33);
        applyStimulus(2, 1'b0, 8'd3, 32'h0);
        waitAcks(1, 20, 1'b1);
        checkOutput("post_reset_latency", 32'(ack_cycle[2]), 32'd3);

        $display("[TB] port 0 withdraws before grant");
        ack0_pulses = 0;
        expectAck(3, 1'b1, 32'h44);
        expectAck(1, 1'b1, 32'h22);
        applyStimulus(3, 1'b0, 8'd4, 32'h0);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 8'd1, 32'h0);
        applyStimulus(1, 1'b0, 8'd2, 32'h0);
        @(posedge clk); #1;
        req[0] = 1'b0;
        waitAcks(2, 30, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("withdrawn_port_ack0", 32'(ack0_pulses), 32'd0);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
